// File: rtl/baccarat_deal_ctrl_pkg.sv
// Shared types and constants for the Baccarat round sequencer: FSM states,
// card codes, scoring thresholds and the face-card value mapping.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_CHK,
    S_P3,
    S_BCHK,
    S_D3,
    S_RES,
    S_DONE
  } state_t;

  localparam logic [3:0] CARD_EMPTY       = 4'd0;
  localparam logic [3:0] CARD_TEN         = 4'd10;
  localparam logic [3:0] CARD_KING        = 4'd13;
  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
  localparam logic [3:0] BANKER_STAND     = 4'd7;

  // Point value of a raw card code: ten and court cards count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code == CARD_EMPTY || (code >= CARD_TEN && code <= CARD_KING))
      return 4'd0;
    return code;
  endfunction

endpackage

// File: rtl/baccarat_deal_ctrl_if.sv
// Handshake bundle between the round sequencer and the card/score datapath.
// The master side drives step and scores; the slave side is the sequencer.
interface baccarat_deal_ctrl_if;
  logic       step;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       done;

  modport master (
    output step, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, done
  );

  modport slave (
    input  step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done
  );
endinterface

// File: rtl/baccarat_deal_ctrl_banker_draw_rule.sv
// Banker third-card rule: decides whether the banker draws given the
// banker's two-card total and the player's third card.
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] w_v;

  assign w_v = card_value(pcard3);

  // NOTE: draw gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (w_v != 4'd8);
      4'd4:             draw = (w_v >= 4'd2) && (w_v <= 4'd7);
      4'd5:             draw = (w_v >= 4'd4) && (w_v <= 4'd7);
      4'd6:             draw = (w_v >= 4'd6) && (w_v <= BANKER_STAND);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat round sequencer: deals cards one per step pulse, applies the
// natural / player-draw / banker-draw rules and latches the round result.
module baccarat_deal_ctrl
  import baccarat_pkg::*;
(
  input  logic                 slow_clock,
  input  logic                 reset,
  baccarat_deal_ctrl_if.slave  bus
);

  state_t     r_state;
  logic       r_pwin;
  logic       r_dwin;
  logic       r_done;
  logic       w_bdraw;
  logic       w_natural;
  logic [5:0] w_load;

  banker_draw_rule u_banker_draw_rule (
    .dscore (bus.dscore),
    .pcard3 (bus.pcard3),
    .draw   (w_bdraw)
  );

  assign w_natural = (bus.pscore >= NATURAL_MIN) || (bus.dscore >= NATURAL_MIN);

  // Load strobes are Mealy: high only in the cycle step is seen in a deal state.
  always_comb begin
    w_load = 6'b0;
    if (!reset && bus.step) begin
      case (r_state)
        S_P1:    w_load[0] = 1'b1;
        S_D1:    w_load[1] = 1'b1;
        S_P2:    w_load[2] = 1'b1;
        S_D2:    w_load[3] = 1'b1;
        S_P3:    w_load[4] = 1'b1;
        S_D3:    w_load[5] = 1'b1;
        default: w_load = 6'b0;
      endcase
    end
  end

  assign bus.load_pcard1      = w_load[0];
  assign bus.load_dcard1      = w_load[1];
  assign bus.load_pcard2      = w_load[2];
  assign bus.load_dcard2      = w_load[3];
  assign bus.load_pcard3      = w_load[4];
  assign bus.load_dcard3      = w_load[5];
  assign bus.player_win_light = r_pwin;
  assign bus.dealer_win_light = r_dwin;
  assign bus.done             = r_done;

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_state <= S_P1;
      r_pwin  <= 1'b0;
      r_dwin  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_P1: if (bus.step) r_state <= S_D1;
        S_D1: if (bus.step) r_state <= S_P2;
        S_P2: if (bus.step) r_state <= S_D2;
        S_D2: if (bus.step) r_state <= S_CHK;
        S_CHK: begin
          if (w_natural)
            r_state <= S_RES;
          else if (bus.pscore < PLAYER_STAND_MIN)
            r_state <= S_P3;
          else if (bus.dscore < PLAYER_STAND_MIN)
            r_state <= S_D3;
          else
            r_state <= S_RES;
        end
        S_P3:   if (bus.step) r_state <= S_BCHK;
        S_BCHK: r_state <= w_bdraw ? S_D3 : S_RES;
        S_D3:   if (bus.step) r_state <= S_RES;
        S_RES: begin
          r_pwin  <= (bus.pscore >= bus.dscore);
          r_dwin  <= (bus.dscore >= bus.pscore);
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_P1;
      endcase
    end
  end

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Self-checking bench for baccarat_deal_ctrl: directed rounds from the test
// plan, randomized rounds against a rule-level model, and the banker table.
module tb_baccarat_deal_ctrl;

  logic slow_clock = 1'b0;
  logic reset      = 1'b1;
  int   n_checks   = 0;
  int   n_errors   = 0;

  baccarat_deal_ctrl_if bus ();

  baccarat_deal_ctrl dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus)
  );

  logic [3:0] rule_d;
  logic [3:0] rule_c;
  logic       rule_draw;

  banker_draw_rule u_rule (
    .dscore (rule_d),
    .pcard3 (rule_c),
    .draw   (rule_draw)
  );

  always #5 slow_clock = ~slow_clock;

  // Card slot order: 0 P1, 1 D1, 2 P2, 3 D2, 4 P3, 5 D3.
  function automatic logic [5:0] strobes();
    return {bus.load_dcard3, bus.load_pcard3, bus.load_dcard2,
            bus.load_pcard2, bus.load_dcard1, bus.load_pcard1};
  endfunction

  function automatic int strobe_idx(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Banker third-card table written straight from the casino rule.
  function automatic bit model_banker(input int d, input int code);
    int v;
    v = (code >= 10) ? 0 : code;
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d == 4) return v inside {[2:7]};
    if (d == 5) return v inside {[4:7]};
    if (d == 6) return v inside {6, 7};
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge slow_clock);
    reset = 1'b1;
    bus.step = 1'b0;
    @(negedge slow_clock);
    reset = 1'b0;
  endtask

  // One full round: expected card order and result come from the rules, the
  // datapath scores are switched in right after the corresponding card edge.
  task automatic play_round(input int p0, input int d0, input int c3,
                            input int pf, input int df, input bit gaps,
                            input string name);
    int   exp_q[$];
    bit   natural, pdraw, bdraw, saw_done;
    int   p_end, d_end, k, pend, last_cyc, last_idx, idx;
    logic [5:0] v;

    natural = (p0 >= 8) || (d0 >= 8);
    pdraw   = !natural && (p0 <= 5);
    bdraw   = natural ? 1'b0 : (!pdraw ? (d0 <= 5) : model_banker(d0, c3));
    exp_q   = {0, 1, 2, 3};
    if (pdraw) exp_q.push_back(4);
    if (bdraw) exp_q.push_back(5);
    p_end = pdraw ? pf : p0;
    d_end = bdraw ? df : d0;

    do_reset();
    bus.pscore = 4'($urandom_range(0, 9));
    bus.dscore = 4'($urandom_range(0, 9));
    bus.pcard3 = 4'd0;
    k = 0; pend = -1; last_cyc = -1; last_idx = -1; saw_done = 1'b0;

    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge slow_clock);
      if (pend == 3) begin bus.pscore = 4'(p0); bus.dscore = 4'(d0); end
      if (pend == 4) begin bus.pscore = 4'(pf); bus.pcard3 = 4'(c3); end
      if (pend == 5) bus.dscore = 4'(df);
      pend = -1;
      bus.step = gaps ? ($urandom_range(0, 3) == 0) : 1'b1;
      #1;
      v = strobes();
      if (bus.done) begin
        saw_done = 1'b1;
        n_checks++;
        if (k != exp_q.size()) begin
          n_errors++;
          $display("FAIL %s card_count: got %0d cards, expected %0d", name, k, exp_q.size());
        end
        n_checks++;
        if (cyc - last_cyc != ((last_idx == 5) ? 2 : 3)) begin
          n_errors++;
          $display("FAIL %s done_latency: got %0d, expected %0d", name,
                   cyc - last_cyc, (last_idx == 5) ? 2 : 3);
        end
        break;
      end
      n_checks++;
      if ($countones(v) > 1 || (!bus.step && v != 6'b0)) begin
        n_errors++;
        $display("FAIL %s strobe_legal: strobes=%b step=%b", name, v, bus.step);
      end
      if (v != 6'b0) begin
        idx = strobe_idx(v);
        n_checks++;
        if (k >= exp_q.size() || idx != exp_q[k]) begin
          n_errors++;
          $display("FAIL %s card_order: got slot %0d, expected %0d", name, idx,
                   (k < exp_q.size()) ? exp_q[k] : -1);
        end
        if (!gaps && last_idx >= 0) begin
          n_checks++;
          if (cyc - last_cyc != ((last_idx == 3 || last_idx == 4) ? 2 : 1)) begin
            n_errors++;
            $display("FAIL %s card_spacing: got %0d cycles after slot %0d", name,
                     cyc - last_cyc, last_idx);
          end
        end
        last_cyc = cyc; last_idx = idx; pend = idx; k++;
      end
    end

    n_checks++;
    if (!saw_done) begin
      n_errors++;
      $display("FAIL %s timeout: done never rose", name);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.player_win_light !== (p_end >= d_end) ||
          bus.dealer_win_light !== (d_end >= p_end) || bus.done !== 1'b1 ||
          strobes() !== 6'b0) begin
        n_errors++;
        $display("FAIL %s result: pwin=%b dwin=%b done=%b strobes=%b, expected pwin=%b dwin=%b done=1 strobes=0",
                 name, bus.player_win_light, bus.dealer_win_light, bus.done, strobes(),
                 p_end >= d_end, d_end >= p_end);
      end
      @(negedge slow_clock);
      bus.step = 1'b1;
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.step = 1'b1;
    repeat (2) @(negedge slow_clock);
    #1;
    n_checks++;
    if (strobes() !== 6'b0 || bus.done !== 1'b0 || bus.player_win_light !== 1'b0 ||
        bus.dealer_win_light !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: strobes=%b done=%b pwin=%b dwin=%b, expected all 0",
               strobes(), bus.done, bus.player_win_light, bus.dealer_win_light);
    end
    @(negedge slow_clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (strobes() !== 6'b000001) begin
      n_errors++;
      $display("FAIL reset_first_card: strobes=%b, expected 000001", strobes());
    end
  endtask

  task automatic test_natural();       play_round(8, 3, 0, 0, 0, 1'b0, "natural");       endtask
  task automatic test_both_draw();     play_round(4, 3, 13, 7, 7, 1'b0, "both_draw");    endtask
  task automatic test_banker_stands(); play_round(2, 3, 8, 0, 0, 1'b0, "banker_stands"); endtask
  task automatic test_player_stands(); play_round(6, 5, 0, 0, 9, 1'b0, "player_stands"); endtask
  task automatic test_gaps();          play_round(4, 3, 5, 1, 2, 1'b1, "gaps");          endtask

  task automatic test_reset_mid_round();
    do_reset();
    bus.pscore = 4'd4; bus.dscore = 4'd3; bus.pcard3 = 4'd0;
    repeat (4) begin @(negedge slow_clock); bus.step = 1'b1; end
    @(negedge slow_clock);
    bus.step = 1'b0;
    repeat (3) @(negedge slow_clock);
    #1;
    n_checks++;
    if (strobes() !== 6'b0) begin
      n_errors++;
      $display("FAIL hold_idle: strobes=%b, expected 0", strobes());
    end
    bus.step = 1'b1;
    #1;
    n_checks++;
    if (strobes() !== 6'b010000) begin
      n_errors++;
      $display("FAIL held_in_p3: strobes=%b, expected 010000", strobes());
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (strobes() !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_cycle_strobe: strobes=%b, expected 0", strobes());
    end
    @(negedge slow_clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (strobes() !== 6'b000001 || bus.done !== 1'b0 || bus.player_win_light !== 1'b0 ||
        bus.dealer_win_light !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_round: strobes=%b done=%b pwin=%b dwin=%b, expected 000001 0 0 0",
               strobes(), bus.done, bus.player_win_light, bus.dealer_win_light);
    end
  endtask

  task automatic test_reset_after_done();
    play_round(9, 1, 0, 0, 0, 1'b0, "pre_reset_round");
    do_reset();
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.player_win_light !== 1'b0 || bus.dealer_win_light !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_after_done: done=%b pwin=%b dwin=%b, expected 0 0 0",
               bus.done, bus.player_win_light, bus.dealer_win_light);
    end
  endtask

  task automatic test_banker_rule();
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 14; c++) begin
        rule_d = 4'(d);
        rule_c = 4'(c);
        #1;
        n_checks++;
        if (rule_draw !== model_banker(d, c)) begin
          n_errors++;
          $display("FAIL banker_rule d=%0d c=%0d: got %b, expected %b", d, c, rule_draw,
                   model_banker(d, c));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      play_round($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 13),
                 $urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom_range(0, 1)),
                 "random");
    end
  endtask

  task automatic test_back_to_back();
    play_round(5, 6, 6, 3, 8, 1'b0, "b2b_a");
    play_round(7, 6, 0, 0, 0, 1'b0, "b2b_b");
    play_round(0, 0, 3, 9, 9, 1'b0, "b2b_c");
  endtask

  initial begin
    bus.step = 1'b0; bus.pscore = 4'd0; bus.dscore = 4'd0; bus.pcard3 = 4'd0;
    rule_d = 4'd0; rule_c = 4'd0;
    test_reset();
    test_natural();
    test_both_draw();
    test_banker_stands();
    test_player_stands();
    test_gaps();
    test_reset_mid_round();
    test_reset_after_done();
    test_banker_rule();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/baccarat_deal_ctrl.md
Name: baccarat_deal_ctrl

Overview:
- Sequencing controller for one Baccarat round.
- Steps dealing through player/dealer card slots 1-3, one card per `step` pulse, and issues a one-cycle load strobe to the external card registers.
- Evaluates the two hand-score datapaths (player, dealer; 4-bit totals mod 10) to apply natural, player-draw and banker-draw rules.
- Latches the win/tie result and holds it until reset.

Parameters:
- None. Card and score widths are fixed at 4 bits by the scoring datapath.

Ports:
- slow_clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; starts a new round
- step  in  1  advance request, one card dealt per high cycle in a deal state
- pscore  in  4  player hand total 0-9 from scoring datapath
- dscore  in  4  dealer hand total 0-9 from scoring datapath
- pcard3  in  4  raw player third card code, 0=empty, 1-13
- load_pcard1, load_pcard2, load_pcard3  out  1 each  one-cycle capture strobes to player card registers
- load_dcard1, load_dcard2, load_dcard3  out  1 each  one-cycle capture strobes to dealer card registers
- player_win_light  out  1  player wins or tie
- dealer_win_light  out  1  dealer wins or tie
- done  out  1  round complete, result valid

Behaviour:
- Reset (synchronous, active-high, has priority over all else):
  - state=S_P1; lights=0; done=0; all load strobes=0 that cycle.
  - Reset mid-round abandons the round immediately.
- Deal states S_P1, S_D1, S_P2, S_D2, S_P3, S_D3:
  - Wait while step=0.
  - With step=1: assert the matching load_* combinationally (Mealy) for that cycle only, and advance on the edge.
  - The card register captures on the same edge; the score inputs are valid from the next cycle.
- Order: S_P1 -> S_D1 -> S_P2 -> S_D2 -> S_CHK.
- S_CHK (one cycle, ignores step):
  - pscore>=8 or dscore>=8 (natural) -> S_RES.
  - Else pscore<=5 -> S_P3.
  - Else (player stands on 6/7): dscore<=5 -> S_D3, else -> S_RES.
- S_P3 -> S_BCHK on step.
- S_BCHK (one cycle): banker draw decision using v = card value of pcard3, where codes 10-13 count as 0.
  - dscore 0-2: draw.
  - dscore 3: draw unless v=8.
  - dscore 4: draw iff v in 2..7.
  - dscore 5: draw iff v in 4..7.
  - dscore 6: draw iff v in 6..7.
  - dscore 7: stand.
  - Draw -> S_D3, else -> S_RES.
- S_D3 -> S_RES on step.
- S_RES (one cycle): compare pscore and dscore and register the result.
  - pscore > dscore: player_win_light=1.
  - pscore < dscore: dealer_win_light=1.
  - Equal: both lights = 1.
  - Set done=1 and go to S_DONE.
- S_DONE: hold lights and done; step ignored; no strobes. Exit only via reset.
- At most one load_* is high in any cycle. No strobe in S_CHK, S_BCHK, S_RES or S_DONE.
- step held high continuously: one card per cycle through consecutive deal states, still pausing one cycle in each evaluation state.
- Score inputs outside 0-9 are a datapath error. The rules treat them with unsigned compare; no checking is done.

Decomposition:
- baccarat_pkg holds:
  - state_t enum (S_P1, S_D1, S_P2, S_D2, S_CHK, S_P3, S_BCHK, S_D3, S_RES, S_DONE)
  - constants CARD_EMPTY=0, CARD_TEN=10, CARD_KING=13, NATURAL_MIN=8, PLAYER_STAND_MIN=6, BANKER_STAND=7
  - function card_value(code) returning 0 for 10-13
- Sub-module banker_draw_rule (combinational): inputs dscore, pcard3; output draw. Kept separate so the rule table can be tested exhaustively.

Test Plan:
- Natural: deal with pscore=8, dscore=3 after S_D2, four step pulses -> exactly four strobes; S_CHK -> S_RES; player_win_light=1, dealer_win_light=0, done=1; further steps produce no strobe.
- Both draw: pscore=4, dscore=3, pcard3=13 (value 0) -> load_pcard3 then load_dcard3 pulses; final pscore=7, dscore=7 -> both lights=1 (tie).
- Banker stands: pscore=2, dscore=3, pcard3=8 -> load_pcard3 only, no load_dcard3; then dscore=3 vs pscore=0 -> dealer_win_light=1.
- Player stands: pscore=6, dscore=5 -> no load_pcard3, load_dcard3 pulses; with dscore then 9 -> dealer wins.
- Gaps and reset: step low for 5 cycles between cards -> no strobes, state held; reset asserted in S_P3 -> next cycle state S_P1, lights/done=0, no strobe in the reset cycle even with step=1.
- banker_draw_rule exhaustive: all dscore 0-7 x pcard3 0-13 -> matches the table, e.g. (4,1)=0, (4,2)=1, (6,7)=1, (3,8)=0.
